// File: rtl/wave_display_mc.sv
// Multi-channel waveform renderer: maps a fixed window of the video sweep onto per-channel
// sample RAM and draws filled traces. Optional background grid enabled by WAVE_GRID_EN.
module wave_display_mc #(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned SAMPLE_W  = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned X_START   = 384,
  parameter int unsigned Y_TOP     = 104,
  parameter logic [95:0] CH_COLORS = {24'h00FF00, 24'hFF00FF, 24'h00FFFF, 24'hFFFF00}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [10:0]                  x,
  input  logic [9:0]                   y,
  input  logic                         valid,
  input  logic                         read_index,
  output logic [ADDR_W:0]              read_address,
  input  logic [NUM_CH*SAMPLE_W-1:0]   read_value,
  output logic                         valid_pixel,
  output logic [7:0]                   r,
  output logic [7:0]                   g,
  output logic [7:0]                   b
);

  localparam int unsigned XW    = 11;
  localparam int unsigned YW    = 10;
  localparam int unsigned WIN_W = 1 << (ADDR_W + 1);
  localparam int unsigned WIN_H = 1 << (SAMPLE_W + 1);
`ifdef WAVE_GRID_EN
  localparam logic [23:0] GRID_RGB = 24'h404040;
`endif

  logic                frozen_idx;
  logic [XW-1:0]       x_rel_c;
  logic [YW-1:0]       y_rel_c;
  logic                in_win_c;
  logic                frame_start_c;
  logic                idx_sel_c;

  logic                s0_valid;
  logic [ADDR_W-1:0]   s0_idx;
  logic [SAMPLE_W-1:0] s0_row;
  logic                s1_valid;
  logic [ADDR_W-1:0]   s1_idx;
  logic [SAMPLE_W-1:0] s1_row;
`ifdef WAVE_GRID_EN
  logic                s0_grid;
  logic                s1_grid;
`endif

  logic [SAMPLE_W-1:0] cur_q  [NUM_CH];
  logic [SAMPLE_W-1:0] prev_q [NUM_CH];
  logic [ADDR_W-1:0]   last_idx;

  logic [SAMPLE_W-1:0] smp_c  [NUM_CH];
  logic [SAMPLE_W-1:0] cur_c  [NUM_CH];
  logic [SAMPLE_W-1:0] prev_c [NUM_CH];
  logic [SAMPLE_W-1:0] lo_c   [NUM_CH];
  logic [SAMPLE_W-1:0] hi_c   [NUM_CH];
  logic [NUM_CH-1:0]   hit_c;
  logic                new_idx_c;
  logic                first_c;
  logic                found_c;
  logic                lit_c;
  logic [23:0]         rgb_c;

  // Window decode and frame-locked buffer select; the frame-start pixel already sees the new half.
  always_comb begin
    x_rel_c       = x - XW'(X_START);
    y_rel_c       = y - YW'(Y_TOP);
    in_win_c      = valid && (x >= XW'(X_START)) && (32'(x_rel_c) < WIN_W)
                    && (y >= YW'(Y_TOP)) && (32'(y_rel_c) < WIN_H);
    frame_start_c = valid && (x == '0) && (y == '0);
    idx_sel_c     = frame_start_c ? read_index : frozen_idx;
  end

  // Sample tracking and hit detection for the pixel whose RAM data is returning now.
  always_comb begin
    new_idx_c = (s1_idx != last_idx);
    first_c   = (s1_idx == '0);
    hit_c     = '0;
    found_c   = 1'b0;
    rgb_c     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      smp_c[c]  = read_value[SAMPLE_W*c +: SAMPLE_W];
      cur_c[c]  = (first_c || new_idx_c) ? smp_c[c] : cur_q[c];
      prev_c[c] = first_c ? smp_c[c] : (new_idx_c ? cur_q[c] : prev_q[c]);
      lo_c[c]   = (prev_c[c] < cur_c[c]) ? prev_c[c] : cur_c[c];
      hi_c[c]   = (prev_c[c] < cur_c[c]) ? cur_c[c] : prev_c[c];
      hit_c[c]  = s1_valid && (lo_c[c] <= s1_row) && (s1_row <= hi_c[c]);
    end
    // Lowest-numbered hitting channel wins.
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (hit_c[c] && !found_c) begin
        rgb_c   = CH_COLORS[24*c +: 24];
        found_c = 1'b1;
      end
    end
`ifdef WAVE_GRID_EN
    lit_c = found_c || (s1_valid && s1_grid);
    if (!found_c && s1_valid && s1_grid) begin
      rgb_c = GRID_RGB;
    end
`else
    lit_c = found_c;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frozen_idx   <= 1'b0;
      read_address <= '0;
      s0_valid     <= 1'b0;
      s0_idx       <= '0;
      s0_row       <= '0;
      s1_valid     <= 1'b0;
      s1_idx       <= '0;
      s1_row       <= '0;
`ifdef WAVE_GRID_EN
      s0_grid      <= 1'b0;
      s1_grid      <= 1'b0;
`endif
      last_idx     <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        cur_q[c]  <= '0;
        prev_q[c] <= '0;
      end
      valid_pixel  <= 1'b0;
      r            <= '0;
      g            <= '0;
      b            <= '0;
    end else begin
      frozen_idx <= idx_sel_c;
      if (in_win_c) begin
        read_address <= {idx_sel_c, x_rel_c[ADDR_W:1]};
      end
      s0_valid <= in_win_c;
      s0_idx   <= x_rel_c[ADDR_W:1];
      s0_row   <= ~y_rel_c[SAMPLE_W:1];
      s1_valid <= s0_valid;
      s1_idx   <= s0_idx;
      s1_row   <= s0_row;
`ifdef WAVE_GRID_EN
      s0_grid  <= (x_rel_c[4:0] == 5'd0) || (y_rel_c[4:0] == 5'd0);
      s1_grid  <= s0_grid;
`endif
      if (s1_valid) begin
        last_idx <= s1_idx;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          cur_q[c]  <= cur_c[c];
          prev_q[c] <= prev_c[c];
        end
      end
      valid_pixel <= lit_c;
      r           <= lit_c ? rgb_c[23:16] : 8'd0;
      g           <= lit_c ? rgb_c[15:8]  : 8'd0;
      b           <= lit_c ? rgb_c[7:0]   : 8'd0;
    end
  end

endmodule

// File: tb/tb_wave_display_mc.sv
// Directed bench for wave_display_mc with a pixel-level reference model and per-cycle compare.
module tb_wave_display_mc;

  localparam int XS = 384;
  localparam int YT = 104;
  localparam logic [23:0] COL0 = 24'hFFFF00;
  localparam logic [23:0] COL1 = 24'h00FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [8:0]  read_address;
  logic [15:0] read_value;
  logic        valid_pixel;
  logic [7:0]  r, g, b;

  logic [7:0] mem0 [0:511];
  logic [7:0] mem1 [0:511];

  int errors = 0;
  int checks = 0;

  wave_display_mc dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .valid(valid), .read_index(read_index),
    .read_address(read_address), .read_value(read_value), .valid_pixel(valid_pixel),
    .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  // Synchronous sample RAM, one cycle read latency.
  always @(posedge clk) read_value <= {mem1[read_address], mem0[read_address]};

  typedef struct packed {
    logic        has;
    logic        vp;
    logic [23:0] rgb;
    int          xr;
    int          yr;
  } px_t;

  px_t  pipe0, pipe1, exp_o, e;
  int   exp_addr;
  logic started = 1'b0;
  int   m_fi, m_last;
  int   m_cur [2];
  int   m_prev[2];
  int   xr, yr, idx, row, s, lo, hi;
  logic grid, hit;

  // Reference model: evaluates each presented pixel from the drawing rules, delayed two cycles.
  always @(posedge clk) begin
    exp_o = pipe1;
    pipe1 = pipe0;
    if (reset) begin
      m_fi = 0; m_last = -1;
      for (int c = 0; c < 2; c++) begin m_cur[c] = 0; m_prev[c] = 0; end
      pipe0 = '0; pipe1 = '0; exp_o = '0; exp_addr = 0;
    end else begin
      e = '0;
      if (valid && x == 0 && y == 0) m_fi = int'(read_index);
      xr = int'(x) - XS;
      yr = int'(y) - YT;
      if (valid && xr >= 0 && xr < 512 && yr >= 0 && yr < 512) begin
        idx = xr / 2;
        row = 255 - yr / 2;
        exp_addr = m_fi * 256 + idx;
        hit = 1'b0;
        for (int c = 0; c < 2; c++) begin
          s = (c == 0) ? int'(mem0[m_fi*256+idx]) : int'(mem1[m_fi*256+idx]);
          if (idx == 0) begin m_prev[c] = s; m_cur[c] = s; end
          else if (idx != m_last) begin m_prev[c] = m_cur[c]; m_cur[c] = s; end
          lo = (m_prev[c] < m_cur[c]) ? m_prev[c] : m_cur[c];
          hi = (m_prev[c] < m_cur[c]) ? m_cur[c] : m_prev[c];
          if (!hit && row >= lo && row <= hi) begin
            hit = 1'b1;
            e.rgb = (c == 0) ? COL0 : COL1;
          end
        end
        m_last = idx;
`ifdef WAVE_GRID_EN
        grid = (xr % 32 == 0) || (yr % 32 == 0);
`else
        grid = 1'b0;
`endif
        if (!hit && grid) e.rgb = 24'h404040;
        e.vp  = hit || grid;
        e.has = 1'b1;
        e.xr  = xr;
        e.yr  = yr;
      end
      pipe0 = e;
    end
    started = 1'b1;
  end

  int   watch_yr = -1;
  logic       w_vp [0:511];
  logic [23:0] w_rgb[0:511];

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (valid_pixel !== exp_o.vp) begin
        errors++;
        $display("FAIL pix_vp t=%0t got %0b exp %0b", $time, valid_pixel, exp_o.vp);
      end
      checks++;
      if ({r, g, b} !== exp_o.rgb) begin
        errors++;
        $display("FAIL pix_rgb t=%0t got %06h exp %06h", $time, {r, g, b}, exp_o.rgb);
      end
      checks++;
      if (read_address !== 9'(exp_addr)) begin
        errors++;
        $display("FAIL addr t=%0t got %03h exp %03h", $time, read_address, 9'(exp_addr));
      end
      if (exp_o.has && exp_o.yr == watch_yr) begin
        w_vp[exp_o.xr]  = valid_pixel;
        w_rgb[exp_o.xr] = {r, g, b};
      end
    end
  end

  task automatic step(input int xx, input int yy, input logic vv);
    x = 11'(xx); y = 10'(yy); valid = vv;
    @(posedge clk); #1;
  endtask

  task automatic expect_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, want);
    end
  endtask

  task automatic sweep(input int yrel, input int x0, input int x1);
    watch_yr = yrel;
    for (int i = 0; i < 512; i++) begin w_vp[i] = 1'b0; w_rgb[i] = '0; end
    for (int xx = x0; xx <= x1; xx++) step(xx, YT + yrel, 1'b1);
    step(0, 1, 1'b0);
    step(0, 1, 1'b0);
    step(0, 1, 1'b0);
  endtask

  task automatic fill(input int v0, input int v1);
    for (int i = 0; i < 512; i++) begin mem0[i] = 8'(v0); mem1[i] = 8'(v1); end
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; valid = 1'b0; read_index = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem0[i] = 8'(255 - i); mem0[256+i] = 8'(i);
      mem1[i] = 8'd0;        mem1[256+i] = 8'd0;
    end

    // Reset held while sweeping in-window pixels.
    for (int i = 0; i < 4; i++) begin
      step(XS + i, YT + 510, 1'b1);
      expect_val("rst_vp", int'(valid_pixel), 0);
      expect_val("rst_rgb", int'({r, g, b}), 0);
      expect_val("rst_addr", int'(read_address), 0);
    end
    reset = 1'b0;
    step(XS, YT + 510, 1'b1);
    expect_val("lat_e0", int'(valid_pixel), 0);
    step(0, 1, 1'b0);
    expect_val("lat_e1", int'(valid_pixel), 0);
    step(0, 1, 1'b0);
    expect_val("lat_e2_vp", int'(valid_pixel), 1);
    expect_val("lat_e2_rgb", int'({r, g, b}), int'(COL1));
    step(0, 1, 1'b0);

    // Switch to buffer 1 at frame start; single ramp trace.
    read_index = 1'b1;
    step(0, 0, 1'b1);
    watch_yr = 310;
    for (int i = 0; i < 512; i++) begin w_vp[i] = 1'b0; w_rgb[i] = '0; end
    for (int xx = XS - 2; xx <= XS + 210; xx++) begin
      step(xx, YT + 310, 1'b1);
      if (xx == XS + 200) expect_val("trace_addr", int'(read_address), 'h164);
    end
    step(0, 1, 1'b0); step(0, 1, 1'b0); step(0, 1, 1'b0);
    expect_val("trace_x199", int'(w_vp[199]), 0);
    expect_val("trace_x200", int'(w_vp[200]), 1);
    expect_val("trace_x201", int'(w_vp[201]), 1);
    expect_val("trace_rgb200", int'(w_rgb[200]), int'(COL0));

    // Mid-frame buffer toggle is held off until next frame start.
    read_index = 1'b0;
    step(XS + 10, 300, 1'b1);
    expect_val("lock_hold", int'(read_address), 'h105);
    step(0, 0, 1'b1);
    expect_val("lock_outwin", int'(read_address), 'h105);
    step(XS + 10, 300, 1'b1);
    expect_val("lock_follow", int'(read_address), 'h005);
    step(0, 1, 1'b0); step(0, 1, 1'b0);

    // Line fill between samples 10 and 50 at column 80.
    fill(50, 255);
    for (int i = 0; i < 40; i++) mem0[i] = 8'd10;
    sweep(2 * (255 - 9), XS, XS + 84);
    expect_val("fill_row9", int'(w_vp[80]), 0);
    sweep(2 * (255 - 10), XS, XS + 84);
    expect_val("fill_row10", int'(w_vp[80]), 1);
    expect_val("fill_rgb10", int'(w_rgb[80]), int'(COL0));
    sweep(2 * (255 - 30), XS, XS + 84);
    expect_val("fill_row30", int'(w_vp[80]), 1);
    sweep(2 * (255 - 50), XS, XS + 84);
    expect_val("fill_row50", int'(w_vp[80]), 1);
    sweep(2 * (255 - 51), XS, XS + 84);
    expect_val("fill_row51", int'(w_vp[80]), 0);

    // Overlapping channels: channel 0 wins.
    fill(128, 128);
    sweep(2 * (255 - 128), XS, XS + 20);
    expect_val("ovl_vp", int'(w_vp[10]), 1);
    expect_val("ovl_rgb", int'(w_rgb[10]), int'(COL0));

    // Grid line pixel with no trace.
    fill(255, 255);
    sweep(64, XS, XS + 40);
`ifdef WAVE_GRID_EN
    expect_val("grid_vp", int'(w_vp[32]), 1);
    expect_val("grid_rgb", int'(w_rgb[32]), 'h404040);
`else
    expect_val("grid_vp", int'(w_vp[32]), 0);
    expect_val("grid_rgb", int'(w_rgb[32]), 0);
`endif

    // Reset mid-line discards in-flight pixels.
    fill(0, 0);
    for (int xx = XS; xx < XS + 6; xx++) step(xx, YT + 510, 1'b1);
    reset = 1'b1;
    step(XS + 6, YT + 510, 1'b1);
    expect_val("midrst_vp", int'(valid_pixel), 0);
    expect_val("midrst_addr", int'(read_address), 0);
    reset = 1'b0;
    step(XS + 7, YT + 510, 1'b1);
    step(0, 1, 1'b0);
    step(0, 1, 1'b0);
    step(0, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
